// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N flattened producer channels merged onto one consumer port.
// The arbiter side uses the slave modport; the producers/consumer side uses master.
interface rr_arb_mux_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_sel
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-input registered mux with valid/ready handshakes; the source channel is chosen by a
// round-robin (MODE=0) or fixed lowest-index (MODE=1) arbiter. One output register, 1-cycle latency.
module rr_arb_mux #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int MODE   = 0,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             xfer;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Wrapped search without modulo: first requester at or above the pointer wins,
  // otherwise the lowest requester overall. With the pointer pinned at 0 this is fixed priority.
  always_comb begin
    logic             hi_vld;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_vld;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] base;
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    base   = (MODE == 0) ? ptr_q : '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.in_valid[i]) begin
        if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = SEL_W'(i);
        end
        if (!hi_vld && (SEL_W'(i) >= base)) begin
          hi_vld = 1'b1;
          hi_idx = SEL_W'(i);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == grant_idx) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en = (state_q == EMPTY) | bus.out_ready;
  assign xfer    = rst_n & load_en & grant_vld;

  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      bus.in_ready[i] = xfer & (SEL_W'(i) == grant_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer)               state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    // Pointer wraps at NUM_IN, not at 2**SEL_W.
    if (xfer && (MODE == 0)) begin
      ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (xfer) begin
        data_q <= grant_data;
        sel_q  <= grant_idx;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = (state_q == FULL);

endmodule
